// File: rtl/pwm_fade_ctrl_pkg.sv
// Shared types and constants for the PWM fade controller slice.
// DUTY_MAX and PERIOD_CYCLES describe the 4-bit PWM generator this block drives.
package pwm_ctrl_pkg;

    localparam int DUTY_W_DEF    = 4;
    localparam int RATE_W_DEF    = 8;
    localparam int PERIOD_CYCLES = 1 << DUTY_W_DEF;

    localparam logic [DUTY_W_DEF-1:0] DUTY_MAX = {DUTY_W_DEF{1'b1}};

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RAMP    = 2'd1,
        BR_UP   = 2'd2,
        BR_DOWN = 2'd3
    } fade_state_t;

endpackage

// File: rtl/pwm_fade_ctrl_if.sv
// Fade command channel: valid/ready handshake carrying target, rate and mode.
interface pwm_fade_ctrl_if #(
    parameter int DUTY_W = pwm_ctrl_pkg::DUTY_W_DEF,
    parameter int RATE_W = pwm_ctrl_pkg::RATE_W_DEF
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic [DUTY_W-1:0] cmd_target;
    logic [RATE_W-1:0] cmd_rate;
    logic              cmd_breathe;

    modport master (
        output cmd_valid, cmd_target, cmd_rate, cmd_breathe,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid, cmd_target, cmd_rate, cmd_breathe,
        output cmd_ready
    );

endinterface

// File: rtl/pwm_step_timer.sv
// Phase counter mirroring the PWM counter, plus a divider that turns every
// max(rate,1) period boundaries into one step event.
module pwm_step_timer #(
    parameter int PERIOD_CYCLES = pwm_ctrl_pkg::PERIOD_CYCLES,
    parameter int RATE_W        = pwm_ctrl_pkg::RATE_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [RATE_W-1:0] rate,
    input  logic              clr,
    output logic              period_end,
    output logic              step
);

    localparam int PH_W = (PERIOD_CYCLES > 1) ? $clog2(PERIOD_CYCLES) : 1;
    localparam logic [PH_W-1:0] PH_LAST = PH_W'(PERIOD_CYCLES - 1);

    logic [PH_W-1:0]   phase;
    logic [RATE_W-1:0] div;
    logic [RATE_W-1:0] div_last;

    // Rate 0 counts as rate 1 here; the jump behaviour is decided by the FSM.
    assign div_last   = (rate == '0) ? '0 : rate - 1'b1;
    assign period_end = (phase == PH_LAST);
    assign step       = period_end && !clr && (div == div_last);

    always_ff @(posedge clk) begin
        if (rst) begin
            phase <= '0;
            div   <= '0;
        end else begin
            phase <= period_end ? '0 : phase + 1'b1;
            if (clr || step)
                div <= '0;
            else if (period_end)
                div <= div + 1'b1;
        end
    end

endmodule

// File: rtl/pwm_fade_ctrl.sv
// Fade sequencer for the PWM duty input: one-shot ramps and breathe sweeps,
// with duty updates confined to PWM period boundaries.
module pwm_fade_ctrl #(
    parameter int DUTY_W        = pwm_ctrl_pkg::DUTY_W_DEF,
    parameter int PERIOD_CYCLES = pwm_ctrl_pkg::PERIOD_CYCLES,
    parameter int RATE_W        = pwm_ctrl_pkg::RATE_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    pwm_fade_ctrl_if.slave    cmd,
    output logic [DUTY_W-1:0] duty_out,
    output logic              period_end,
    output logic              busy,
    output logic              done
);

    import pwm_ctrl_pkg::*;

    localparam logic [DUTY_W-1:0] D_MAX = {DUTY_W{1'b1}};

    fade_state_t       state;
    fade_state_t       state_nxt;
    logic [DUTY_W-1:0] target_q;
    logic [RATE_W-1:0] rate_q;
    logic [DUTY_W-1:0] duty_nxt;
    logic [DUTY_W-1:0] duty_up;
    logic [DUTY_W-1:0] duty_dn;
    logic              done_nxt;
    logic              accept;
    logic              step;

    assign cmd.cmd_ready = (state != RAMP);
    assign accept        = cmd.cmd_valid && cmd.cmd_ready;
    assign busy          = (state != IDLE);

    // The divider uses the latched rate; an accept clears it and masks the step.
    pwm_step_timer #(
        .PERIOD_CYCLES (PERIOD_CYCLES),
        .RATE_W        (RATE_W)
    ) u_timer (
        .clk        (clk),
        .rst        (rst),
        .rate       (rate_q),
        .clr        (accept),
        .period_end (period_end),
        .step       (step)
    );

    assign duty_up = (duty_out == D_MAX) ? duty_out : duty_out + 1'b1;
    assign duty_dn = (duty_out == '0)    ? duty_out : duty_out - 1'b1;

    always_comb begin
        state_nxt = state;
        duty_nxt  = duty_out;
        done_nxt  = 1'b0;
        if (accept) begin
            state_nxt = cmd.cmd_breathe ? BR_UP : RAMP;
        end else if (step) begin
            case (state)
                RAMP: begin
                    if (rate_q == '0)
                        duty_nxt = target_q;
                    else if (duty_out < target_q)
                        duty_nxt = duty_up;
                    else if (duty_out > target_q)
                        duty_nxt = duty_dn;
                    if (duty_nxt == target_q) begin
                        state_nxt = IDLE;
                        done_nxt  = 1'b1;
                    end
                end
                // Entering above the peak walks down to it before sweeping.
                BR_UP: begin
                    if (duty_out < target_q)
                        duty_nxt = duty_up;
                    else if (duty_out > target_q)
                        duty_nxt = duty_dn;
                    if (duty_nxt == target_q)
                        state_nxt = BR_DOWN;
                end
                BR_DOWN: begin
                    duty_nxt = duty_dn;
                    if (duty_nxt == '0)
                        state_nxt = BR_UP;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            duty_out <= '0;
            done     <= 1'b0;
            target_q <= '0;
            rate_q   <= '0;
        end else begin
            state    <= state_nxt;
            duty_out <= duty_nxt;
            done     <= done_nxt;
            if (accept) begin
                target_q <= cmd.cmd_target;
                rate_q   <= cmd.cmd_rate;
            end
        end
    end

endmodule

// File: tb/tb_pwm_fade_ctrl.sv
// Directed bench for pwm_fade_ctrl: a vector table walked from reset, then
// hand sequences for boundary-coincident accepts, held commands and reset.
module tb_pwm_fade_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] duty_out;
    logic       period_end;
    logic       busy;
    logic       done;

    int nvec = 0;
    int nerr = 0;

    pwm_fade_ctrl_if #(.DUTY_W(4), .RATE_W(8)) cmd_if ();

    pwm_fade_ctrl #(
        .DUTY_W        (4),
        .PERIOD_CYCLES (16),
        .RATE_W        (8)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .cmd        (cmd_if),
        .duty_out   (duty_out),
        .period_end (period_end),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        string      name;
        logic       valid;
        logic [3:0] target;
        logic [7:0] rate;
        logic       breathe;
        int         cycles;
        logic [3:0] duty;
        logic       ready;
        logic       bsy;
        logic       dn;
        logic       pe;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input string name, input int v, input int tgt, input int rate,
                                input int br, input int cyc, input int d, input int r,
                                input int b, input int dn, input int pe);
        vec_t x;
        x.name    = name;
        x.valid   = 1'(v);
        x.target  = 4'(tgt);
        x.rate    = 8'(rate);
        x.breathe = 1'(br);
        x.cycles  = cyc;
        x.duty    = 4'(d);
        x.ready   = 1'(r);
        x.bsy     = 1'(b);
        x.dn      = 1'(dn);
        x.pe      = 1'(pe);
        return x;
    endfunction

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drive(input logic v, input logic [3:0] tgt, input logic [7:0] rate, input logic br);
        cmd_if.cmd_valid   = v;
        cmd_if.cmd_target  = tgt;
        cmd_if.cmd_rate    = rate;
        cmd_if.cmd_breathe = br;
    endtask

    task automatic check(input string name, input logic [3:0] d, input logic r, input logic b,
                         input logic dn, input logic pe);
        nvec++;
        if (duty_out !== d || cmd_if.cmd_ready !== r || busy !== b || done !== dn || period_end !== pe) begin
            nerr++;
            $display("FAIL %s: got duty=%0d ready=%b busy=%b done=%b pe=%b, want duty=%0d ready=%b busy=%b done=%b pe=%b",
                     name, duty_out, cmd_if.cmd_ready, busy, done, period_end, d, r, b, dn, pe);
        end
    endtask

    initial begin
        // cycle index after each vector noted on the right (0 = first cycle out of reset)
        tbl.push_back(mk("reset",        0,  0, 0, 0,   0,  0, 1, 0, 0, 0)); //   0
        tbl.push_back(mk("pe_15",        0,  0, 0, 0,  15,  0, 1, 0, 0, 1)); //  15
        tbl.push_back(mk("pe_31",        0,  0, 0, 0,  16,  0, 1, 0, 0, 1)); //  31
        tbl.push_back(mk("pe_47",        0,  0, 0, 0,  16,  0, 1, 0, 0, 1)); //  47
        tbl.push_back(mk("idle_48",      0,  0, 0, 0,   1,  0, 1, 0, 0, 0)); //  48
        tbl.push_back(mk("ramp5_acc",    1,  5, 2, 0,   1,  0, 0, 1, 0, 0)); //  49
        tbl.push_back(mk("ramp5_p1",     0,  0, 0, 0,  15,  0, 0, 1, 0, 0)); //  64
        tbl.push_back(mk("ramp5_d1",     0,  0, 0, 0,  16,  1, 0, 1, 0, 0)); //  80
        tbl.push_back(mk("ramp5_d2",     0,  0, 0, 0,  32,  2, 0, 1, 0, 0)); // 112
        tbl.push_back(mk("ramp5_d4pe",   0,  0, 0, 0,  95,  4, 0, 1, 0, 1)); // 207
        tbl.push_back(mk("ramp5_done",   0,  0, 0, 0,   1,  5, 1, 0, 1, 0)); // 208
        tbl.push_back(mk("ramp5_after",  0,  0, 0, 0,   1,  5, 1, 0, 0, 0)); // 209
        tbl.push_back(mk("jump12_acc",   1, 12, 0, 0,   1,  5, 0, 1, 0, 0)); // 210
        tbl.push_back(mk("jump12_pe",    0,  0, 0, 0,  13,  5, 0, 1, 0, 1)); // 223
        tbl.push_back(mk("jump12_done",  0,  0, 0, 0,   1, 12, 1, 0, 1, 0)); // 224
        tbl.push_back(mk("jump12_after", 0,  0, 0, 0,   1, 12, 1, 0, 0, 0)); // 225
        tbl.push_back(mk("jump0_acc",    1,  0, 0, 0,   1, 12, 0, 1, 0, 0)); // 226
        tbl.push_back(mk("jump0_done",   0,  0, 0, 0,  14,  0, 1, 0, 1, 0)); // 240
        tbl.push_back(mk("br3_acc",      1,  3, 1, 1,   1,  0, 1, 1, 0, 0)); // 241
        tbl.push_back(mk("br3_1",        0,  0, 0, 0,  15,  1, 1, 1, 0, 0)); // 256
        tbl.push_back(mk("br3_2",        0,  0, 0, 0,  16,  2, 1, 1, 0, 0)); // 272
        tbl.push_back(mk("br3_3",        0,  0, 0, 0,  16,  3, 1, 1, 0, 0)); // 288
        tbl.push_back(mk("br3_2dn",      0,  0, 0, 0,  16,  2, 1, 1, 0, 0)); // 304
        tbl.push_back(mk("br3_1dn",      0,  0, 0, 0,  16,  1, 1, 1, 0, 0)); // 320
        tbl.push_back(mk("br3_0",        0,  0, 0, 0,  16,  0, 1, 1, 0, 0)); // 336
        tbl.push_back(mk("br3_1up",      0,  0, 0, 0,  16,  1, 1, 1, 0, 0)); // 352
        tbl.push_back(mk("br3_2up",      0,  0, 0, 0,  16,  2, 1, 1, 0, 0)); // 368
        tbl.push_back(mk("ramp15_acc",   1, 15, 1, 0,   1,  2, 0, 1, 0, 0)); // 369
        tbl.push_back(mk("ramp15_3",     0,  0, 0, 0,  15,  3, 0, 1, 0, 0)); // 384
        tbl.push_back(mk("ramp15_14",    0,  0, 0, 0, 176, 14, 0, 1, 0, 0)); // 560
        tbl.push_back(mk("ramp15_done",  0,  0, 0, 0,  16, 15, 1, 0, 1, 0)); // 576

        drive(1'b0, 4'd0, 8'd0, 1'b0);
        rst = 1'b1;
        tick(2);
        rst = 1'b0;

        foreach (tbl[i]) begin
            drive(tbl[i].valid, tbl[i].target, tbl[i].rate, tbl[i].breathe);
            tick(tbl[i].cycles);
            cmd_if.cmd_valid = 1'b0;
            check(tbl[i].name, tbl[i].duty, tbl[i].ready, tbl[i].bsy, tbl[i].dn, tbl[i].pe);
        end

        // Accept on a period_end cycle with rate 2: that boundary must not count.
        tick(15);                                                     // 591
        check("coinc_pre", 4'd15, 1'b1, 1'b0, 1'b0, 1'b1);
        drive(1'b1, 4'd13, 8'd2, 1'b0);
        tick(1);                                                      // 592
        cmd_if.cmd_valid = 1'b0;
        check("coinc_acc", 4'd15, 1'b0, 1'b1, 1'b0, 1'b0);
        tick(16);                                                     // 608
        check("coinc_nostep", 4'd15, 1'b0, 1'b1, 1'b0, 1'b0);
        tick(16);                                                     // 624
        check("coinc_step", 4'd14, 1'b0, 1'b1, 1'b0, 1'b0);

        // Command held during RAMP is taken the cycle ready rises.
        drive(1'b1, 4'd0, 8'd0, 1'b0);
        tick(16);                                                     // 640
        check("held_blocked", 4'd14, 1'b0, 1'b1, 1'b0, 1'b0);
        tick(16);                                                     // 656
        check("held_done", 4'd13, 1'b1, 1'b0, 1'b1, 1'b0);
        tick(1);                                                      // 657
        cmd_if.cmd_valid = 1'b0;
        check("held_taken", 4'd13, 1'b0, 1'b1, 1'b0, 1'b0);
        tick(15);                                                     // 672
        check("held_jump0", 4'd0, 1'b1, 1'b0, 1'b1, 1'b0);

        // Reset mid-ramp at duty 7.
        drive(1'b1, 4'd12, 8'd1, 1'b0);
        tick(1);                                                      // 673
        cmd_if.cmd_valid = 1'b0;
        tick(112);                                                    // 785
        check("rst_pre", 4'd7, 1'b0, 1'b1, 1'b0, 1'b0);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;                                                   // new cycle 0
        check("rst_mid", 4'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 4'd2, 8'd1, 1'b0);
        tick(1);                                                      // 1
        cmd_if.cmd_valid = 1'b0;
        check("post_rst_acc", 4'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        tick(15);                                                     // 16
        check("post_rst_d1", 4'd1, 1'b0, 1'b1, 1'b0, 1'b0);
        tick(16);                                                     // 32
        check("post_rst_done", 4'd2, 1'b1, 1'b0, 1'b1, 1'b0);

        // Target equal to current duty: first step changes nothing but finishes.
        drive(1'b1, 4'd2, 8'd1, 1'b0);
        tick(1);                                                      // 33
        cmd_if.cmd_valid = 1'b0;
        check("same_acc", 4'd2, 1'b0, 1'b1, 1'b0, 1'b0);
        tick(15);                                                     // 48
        check("same_done", 4'd2, 1'b1, 1'b0, 1'b1, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
